// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if
// Three-wire TM1638 serial link (STB/CLK/DIO) between the board controller
// (master) and the responder model (slave).
//   sio_clk      serial clock, driven by the master
//   sio_stb      strobe, active low, driven by the master
//   sio_data_in  DIO as seen on the wire, driven by the master
//   sio_data_out DIO value returned by the slave during key reads
//   sio_data_oe  slave DIO output enable
interface tm1638_responder_if;
  logic sio_clk;
  logic sio_stb;
  logic sio_data_in;
  logic sio_data_out;
  logic sio_data_oe;

  modport master (
    output sio_clk, sio_stb, sio_data_in,
    input  sio_data_out, sio_data_oe
  );

  modport slave (
    input  sio_clk, sio_stb, sio_data_in,
    output sio_data_out, sio_data_oe
  );
endinterface

// File: rtl/tm1638_responder.sv
// tm1638_responder
// Responder end of a TM1638 serial link. Decodes data, address and
// display-control commands into a 16-byte display RAM and returns four
// key-scan bytes on read commands.
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   sio              serial link (slave modport of tm1638_responder_if)
//   keys[7:0]        key states, 1 = pressed
//   hgfedcba[63:0]   digit n segments = RAM[2n] at [8n+7:8n]
//   ledr[7:0]        bit n = RAM[2n+1] bit 0
//   display_on       display-control bit 3
//   brightness[2:0]  display-control bits 2:0
//   frame_done       one-cycle pulse per synchronized STB rise
//   protocol_error   sticky framing/command error flag
// Optional feature: define TM1638_RESPONDER_CHECK_EN to build the protocol
// checker; otherwise protocol_error is tied low.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  tm1638_responder_if.slave sio,
  input  logic [7:0]        keys,
  output logic [63:0]       hgfedcba,
  output logic [7:0]        ledr,
  output logic              display_on,
  output logic [2:0]        brightness,
  output logic              frame_done,
  output logic              protocol_error
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_SKIP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg, stb_sync_reg, din_sync_reg;
  logic                   clk_prev_reg, stb_prev_reg;
  // Edges are masked until the synchronizers have refilled after reset, so a
  // reset taken mid-frame does not fake an STB fall and the frame resumes
  // only at the next real STB fall.
  logic [SYNC_STAGES:0]   warm_reg;

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [3:0]  addr_reg;
  logic        fixed_reg;
  logic [7:0]  ram_reg [16];
  logic        display_on_reg;
  logic [2:0]  brightness_reg;
  logic        data_out_reg, data_oe_reg, frame_done_reg;
  logic [5:0]  rd_cnt_reg;      // bits driven this read frame, saturates at 63
  logic [7:0]  rd_byte_reg;

  logic clk_s, stb_s, din_s, edges_ok;
  logic clk_rise, clk_fall, stb_rise, stb_fall;
  logic bit_event, byte_done;
  logic [7:0] byte_val;
  logic [1:0] rd_idx;
  logic [7:0] key_byte;

  assign clk_s    = clk_sync_reg[SYNC_STAGES-1];
  assign stb_s    = stb_sync_reg[SYNC_STAGES-1];
  assign din_s    = din_sync_reg[SYNC_STAGES-1];
  assign edges_ok = warm_reg[SYNC_STAGES];
  assign clk_rise = edges_ok &  clk_s & ~clk_prev_reg;
  assign clk_fall = edges_ok & ~clk_s &  clk_prev_reg;
  assign stb_rise = edges_ok &  stb_s & ~stb_prev_reg;
  assign stb_fall = edges_ok & ~stb_s &  stb_prev_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_reg <= '1;
      stb_sync_reg <= '1;
      din_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
      stb_prev_reg <= 1'b1;
      warm_reg     <= '0;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], sio.sio_clk};
      stb_sync_reg <= {stb_sync_reg[SYNC_STAGES-2:0], sio.sio_stb};
      din_sync_reg <= {din_sync_reg[SYNC_STAGES-2:0], sio.sio_data_in};
      clk_prev_reg <= clk_s;
      stb_prev_reg <= stb_s;
      warm_reg     <= {warm_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // An STB rise in the same cycle as a CLK edge wins; the bit is dropped.
  assign bit_event = clk_rise & ~stb_rise & (state_reg != ST_IDLE);
  assign byte_done = bit_event & (bit_cnt_reg == 3'd7);
  assign byte_val  = {din_s, shift_reg[7:1]};   // LSB first: new bit enters at the top

  // Key byte n carries keys[n] in bit 0 and keys[n+4] in bit 4.
  assign rd_idx   = rd_cnt_reg[4:3];
  assign key_byte = {3'b000, keys[{1'b1, rd_idx}], 3'b000, keys[{1'b0, rd_idx}]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (stb_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (stb_fall) state_next = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (byte_val[7:6])
              2'b01:   state_next = byte_val[1] ? ST_RDATA : ST_SKIP;
              2'b11:   state_next = ST_WDATA;
              default: state_next = ST_SKIP;
            endcase
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      addr_reg       <= '0;
      fixed_reg      <= 1'b0;
      for (int i = 0; i < 16; i++) ram_reg[i] <= '0;
      display_on_reg <= 1'b0;
      brightness_reg <= '0;
      data_out_reg   <= 1'b1;
      data_oe_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      rd_cnt_reg     <= '0;
      rd_byte_reg    <= '0;
    end else begin
      frame_done_reg <= stb_rise;
      if (stb_rise) begin
        // Frame end: release DIO and discard any partial byte.
        data_oe_reg  <= 1'b0;
        data_out_reg <= 1'b1;
        bit_cnt_reg  <= '0;
      end else begin
        if (state_reg == ST_IDLE && stb_fall) begin
          bit_cnt_reg <= '0;
          rd_cnt_reg  <= '0;
        end
        if (bit_event) begin
          shift_reg   <= byte_val;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        if (byte_done && state_reg == ST_CMD) begin
          case (byte_val[7:6])
            2'b01: fixed_reg <= byte_val[2];
            2'b10: begin
              display_on_reg <= byte_val[3];
              brightness_reg <= byte_val[2:0];
            end
            2'b11:   addr_reg <= byte_val[3:0];
            default: ;
          endcase
        end
        if (byte_done && state_reg == ST_WDATA) begin
          ram_reg[addr_reg] <= byte_val;
          if (!fixed_reg) addr_reg <= addr_reg + 4'd1;
        end
        if (clk_fall && state_reg == ST_RDATA) begin
          data_oe_reg <= 1'b1;
          if (rd_cnt_reg[5]) begin
            data_out_reg <= 1'b0;
          end else if (rd_cnt_reg[2:0] == 3'd0) begin
            // Snapshot keys once per byte so the byte is self-consistent.
            rd_byte_reg  <= key_byte;
            data_out_reg <= key_byte[0];
          end else begin
            data_out_reg <= rd_byte_reg[rd_cnt_reg[2:0]];
          end
          if (rd_cnt_reg != 6'h3F) rd_cnt_reg <= rd_cnt_reg + 6'd1;
        end
      end
    end
  end

  assign sio.sio_data_out = data_out_reg;
  assign sio.sio_data_oe  = data_oe_reg;
  assign display_on       = display_on_reg;
  assign brightness       = brightness_reg;
  assign frame_done       = frame_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_out
      logic [6:0] led_hi_unused;
      assign hgfedcba[8*gi +: 8] = ram_reg[2*gi];
      assign ledr[gi]            = ram_reg[2*gi+1][0];
      assign led_hi_unused       = ram_reg[2*gi+1][7:1];
    end
  endgenerate

`ifdef TM1638_RESPONDER_CHECK_EN
  logic err_reg;
  logic err_event;

  // A read byte is "received" only once all 32 key bits have been returned
  // and a further full byte is clocked; the 32nd rise itself is legal.
  always_comb begin
    err_event = 1'b0;
    if (stb_rise && bit_cnt_reg != 3'd0)                            err_event = 1'b1;
    if (byte_done && state_reg == ST_RDATA && rd_cnt_reg > 6'd32)    err_event = 1'b1;
    if (byte_done && state_reg == ST_CMD && byte_val[7:6] == 2'b00)  err_event = 1'b1;
    if (stb_rise && state_reg == ST_RDATA && rd_cnt_reg < 6'd32)     err_event = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_reg <= 1'b0;
    else       err_reg <= err_reg | err_event;
  end

  assign protocol_error = err_reg;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder
// Drives the TM1638 link as the board controller would and compares the
// responder's outputs against a frame-level reference model.
module tb_tm1638_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  keys;
  logic [63:0] hgfedcba;
  logic [7:0]  ledr;
  logic        display_on;
  logic [2:0]  brightness;
  logic        frame_done;
  logic        protocol_error;

  always #5 clock = ~clock;

  tm1638_responder_if sio ();

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .sio            (sio),
    .keys           (keys),
    .hgfedcba       (hgfedcba),
    .ledr           (ledr),
    .display_on     (display_on),
    .brightness     (brightness),
    .frame_done     (frame_done),
    .protocol_error (protocol_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // frame_done pulse counter
  int fd_cnt = 0;
  int fd_exp = 0;
  bit fd_ignore = 1'b0;
  always @(posedge clock) if (frame_done === 1'b1 && !fd_ignore) fd_cnt++;

  // Reference model: display RAM, write pointer and latched modes.
  logic [7:0] m_ram [16];
  int         m_addr;
  bit         m_fixed, m_on, m_err;
  logic [2:0] m_bri;

  task model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr = 0; m_fixed = 0; m_on = 0; m_bri = 3'd0; m_err = 0;
  endtask

  task model_frame(input logic [7:0] fb[$]);
    logic [7:0] cmd;
    if (fb.size() == 0) return;
    cmd = fb[0];
    case (cmd[7:6])
      2'b01: m_fixed = cmd[2];
      2'b10: begin m_on = cmd[3]; m_bri = cmd[2:0]; end
      2'b11: begin
        m_addr = cmd[3:0];
        for (int i = 1; i < fb.size(); i++) begin
          m_ram[m_addr] = fb[i];
          if (!m_fixed) m_addr = (m_addr + 1) % 16;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [63:0] exp_seg();
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[8*n +: 8] = m_ram[2*n];
    return r;
  endfunction

  function automatic logic [7:0] exp_led();
    logic [7:0] r;
    for (int n = 0; n < 8; n++) r[n] = m_ram[2*n+1][0];
    return r;
  endfunction

  task check_outputs(input string tag);
    check_value({tag, "_seg"}, hgfedcba, exp_seg());
    check_value({tag, "_led"}, ledr, exp_led());
    check_value({tag, "_on"}, display_on, m_on);
    check_value({tag, "_bri"}, brightness, m_bri);
    check_value({tag, "_oe"}, sio.sio_data_oe, 1'b0);
    check_value({tag, "_err"}, protocol_error, m_err);
    check_value({tag, "_fd"}, fd_cnt, fd_exp);
  endtask

  // One serial phase: 8 system clocks, comfortably above SYNC_STAGES+2.
  task half();
    repeat (8) @(posedge clock);
    #1;
  endtask

  task send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sio.sio_clk = 1'b0;
      sio.sio_data_in = b[i];
      half();
      sio.sio_clk = 1'b1;
      half();
    end
  endtask

  task send_frame(input string tag, input logic [7:0] fb[$]);
    sio.sio_stb = 1'b0;
    half();
    for (int i = 0; i < fb.size(); i++) send_bits(fb[i], 8);
    sio.sio_stb = 1'b1;
    fd_exp++;
    half(); half();
    model_frame(fb);
    $display("frame %s: cmd %h, %0d data bytes", tag, fb[0], fb.size() - 1);
    check_outputs(tag);
  endtask

  // Read frame: kseq[8n+:8] is the key state presented while byte n starts;
  // with mid set, keys change again mid-byte and must not affect that byte.
  task read_frame(input string tag, input logic [7:0] cmd, input logic [31:0] kseq, input bit mid);
    logic [7:0] got, exp;
    logic [7:0] q[$];
    sio.sio_stb = 1'b0;
    half();
    send_bits(cmd, 8);
    for (int n = 0; n < 4; n++) begin
      keys = kseq[8*n +: 8];
      exp = 8'h00;
      exp[0] = kseq[8*n + n];
      exp[4] = kseq[8*n + n + 4];
      for (int b = 0; b < 8; b++) begin
        sio.sio_clk = 1'b0;
        sio.sio_data_in = 1'b1;
        if (mid && b == 4) keys = 8'($urandom);
        half();
        got[b] = sio.sio_data_out;
        check_value({tag, "_rd_oe"}, sio.sio_data_oe, 1'b1);
        sio.sio_clk = 1'b1;
        half();
      end
      $display("read %s byte %0d: got %h expected %h", tag, n, got, exp);
      check_value({tag, "_rd_byte"}, got, exp);
    end
    sio.sio_stb = 1'b1;
    fd_exp++;
    half(); half();
    q.push_back(cmd);
    model_frame(q);
    check_outputs(tag);
  endtask

  logic [7:0] q[$];
  int kind, nbytes;

  initial begin
    reset = 1'b1;
    keys = 8'h00;
    sio.sio_clk = 1'b1;
    sio.sio_stb = 1'b1;
    sio.sio_data_in = 1'b1;
    model_reset();
    #1;
    check_value("rst_seg", hgfedcba, 64'h0);
    check_value("rst_dout", sio.sio_data_out, 1'b1);
    check_value("rst_oe", sio.sio_data_oe, 1'b0);
    check_value("rst_fd", frame_done, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check_outputs("idle");
    check_value("idle_dout", sio.sio_data_out, 1'b1);

    // display control
    q.delete(); q.push_back(8'h8F);
    send_frame("disp", q);

    // auto-increment write of all 16 bytes
    q.delete(); q.push_back(8'h40);
    send_frame("dcmd_auto", q);
    q.delete(); q.push_back(8'hC0);
    q.push_back(8'h3F); q.push_back(8'h01); q.push_back(8'h06); q.push_back(8'h00);
    for (int i = 4; i < 16; i++) q.push_back(8'($urandom));
    send_frame("wr16", q);

    // fixed address overwrite
    q.delete(); q.push_back(8'h44);
    send_frame("dcmd_fixed", q);
    q.delete(); q.push_back(8'hC5); q.push_back(8'h01); q.push_back(8'h00);
    send_frame("fixed2", q);
    q.delete(); q.push_back(8'hC5); q.push_back(8'h01);
    send_frame("fixed1", q);

    // key read
    read_frame("rd11", 8'h42, {4{8'h11}}, 1'b0);
    read_frame("rdrnd", 8'h42, $urandom, 1'b1);

    // address wrap
    q.delete(); q.push_back(8'h40);
    send_frame("dcmd_wrap", q);
    q.delete(); q.push_back(8'hCF); q.push_back(8'hAA); q.push_back(8'h55);
    send_frame("wrap", q);

    // randomized frames
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      q.delete();
      case (kind)
        0: begin
          q.push_back(8'h40 | (8'($urandom) & 8'h3D));
          send_frame("r_dcmd", q);
        end
        1: begin
          q.push_back(8'h80 | (8'($urandom) & 8'h3F));
          send_frame("r_disp", q);
        end
        2: begin
          q.push_back(8'hC0 | (8'($urandom) & 8'h3F));
          nbytes = $urandom_range(0, 18);
          for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom));
          send_frame("r_addr", q);
        end
        default: read_frame("r_read", 8'h42 | (8'($urandom) & 8'h3D), $urandom, 1'b1);
      endcase
    end

    // asynchronous reset in the middle of a write frame
    sio.sio_stb = 1'b0;
    half();
    send_bits(8'hC0, 8);
    send_bits(8'h5A, 8);
    send_bits(8'h77, 3);
    @(posedge clock);
    #3 reset = 1'b1;
    fd_ignore = 1'b1;
    #1;
    check_value("mid_rst_seg", hgfedcba, 64'h0);
    check_value("mid_rst_led", ledr, 8'h00);
    check_value("mid_rst_on", display_on, 1'b0);
    check_value("mid_rst_bri", brightness, 3'd0);
    check_value("mid_rst_dout", sio.sio_data_out, 1'b1);
    check_value("mid_rst_err", protocol_error, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    half();
    sio.sio_stb = 1'b1;
    half(); half();
    fd_ignore = 1'b0;
    check_outputs("post_rst");
    q.delete(); q.push_back(8'h8B);
    send_frame("post_rst_disp", q);
    q.delete(); q.push_back(8'hC2); q.push_back(8'hA5); q.push_back(8'h81);
    send_frame("post_rst_wr", q);

`ifdef TM1638_RESPONDER_CHECK_EN
    // truncated command byte: 3 bits then STB rise
    sio.sio_stb = 1'b0;
    half();
    send_bits(8'h8F, 3);
    sio.sio_stb = 1'b1;
    fd_exp++;
    half(); half();
    m_err = 1'b1;
    check_outputs("trunc");
    q.delete(); q.push_back(8'h88);
    send_frame("sticky", q);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
